// File: rtl/huffman_job_sched_if.sv
// -----------------------------------------------------------------------------
// huffman_job_sched_if
// Bundles every signal between the job scheduler, its two symbol requesters
// and the shared huffman encoder core.
//
// Handshake rules: a symbol moves from requester n to the scheduler on a
// rising clock edge where sym_valid[n] and sym_ready[n] are both 1. sym_ready
// is never asserted for more than one requester at a time, and it does not
// depend on sym_valid. A requester may change sym_data/sym_valid freely while
// its sym_ready is low. core_gray_valid is a one-cycle push into the core that
// the core cannot stall. core_code_valid is only looked at while the scheduler
// waits for a code table. res_valid is a one-cycle strobe; the res_* fields
// hold their value until the next strobe.
//
// Signals (direction as seen by the scheduler, i.e. modport slave):
//   req[1:0]          in   level job request per requester
//   sym_valid[1:0]    in   symbol valid per requester
//   sym_data0/1[7:0]  in   symbol of requester 0/1 (legal 1..6)
//   sym_ready[1:0]    out  one-hot ready toward the current owner
//   busy              out  scheduler not idle
//   core_rst          out  core reset
//   core_gray_valid   out  symbol push into the core
//   core_gray_data    out  symbol pushed into the core
//   core_code_valid   in   core code table ready
//   core_hc/core_m    in   {HC6..HC1} / {M6..M1}, entry 1 in [7:0]
//   res_valid         out  result strobe
//   res_id            out  requester owning the result
//   res_err[1:0]      out  0 ok, 1 bad symbol, 2 timeout
//   res_hc/res_m      out  captured codes/masks, zero on error
//   dbg_state[2:0]    out  scheduler state, for observation only
// -----------------------------------------------------------------------------
interface huffman_job_sched_if;
  logic [1:0]  req;
  logic [1:0]  sym_valid;
  logic [7:0]  sym_data0;
  logic [7:0]  sym_data1;
  logic [1:0]  sym_ready;
  logic        busy;
  logic        core_rst;
  logic        core_gray_valid;
  logic [7:0]  core_gray_data;
  logic        core_code_valid;
  logic [47:0] core_hc;
  logic [47:0] core_m;
  logic        res_valid;
  logic        res_id;
  logic [1:0]  res_err;
  logic [47:0] res_hc;
  logic [47:0] res_m;
  logic [2:0]  dbg_state;

  // Scheduler side.
  modport slave (
    input  req, sym_valid, sym_data0, sym_data1,
    input  core_code_valid, core_hc, core_m,
    output sym_ready, busy, core_rst, core_gray_valid, core_gray_data,
    output res_valid, res_id, res_err, res_hc, res_m, dbg_state
  );

  // Requesters + core side.
  modport master (
    output req, sym_valid, sym_data0, sym_data1,
    output core_code_valid, core_hc, core_m,
    input  sym_ready, busy, core_rst, core_gray_valid, core_gray_data,
    input  res_valid, res_id, res_err, res_hc, res_m, dbg_state
  );
endinterface

// File: rtl/huffman_job_sched.sv
// -----------------------------------------------------------------------------
// huffman_job_sched
// Shares one huffman encoder core between two symbol requesters. A requester
// is granted round-robin, its SYM_NUM symbols are streamed into the core, the
// core's code table is captured and returned tagged with the requester id,
// and the core is reset before the next job.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    huffman_job_sched_if.slave (see the interface file for signals)
//
// Parameters:
//   SYM_NUM  symbols per job (must match the core)
//   TIMEOUT  cycles allowed in WAIT_CODE before the job is aborted
//   RST_CYC  cycles core_rst is held high between jobs (>= 1)
// -----------------------------------------------------------------------------
module huffman_job_sched #(
  parameter int SYM_NUM = 100,
  parameter int TIMEOUT = 1023,
  parameter int RST_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  huffman_job_sched_if.slave  bus
);

  localparam int CW = $clog2(SYM_NUM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_NUM - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [FW-1:0] r_fcnt;
  logic          r_core_rst;
  logic          r_gray_valid;
  logic [7:0]    r_gray_data;
  logic          r_res_valid;
  logic          r_res_id;
  logic [1:0]    r_res_err;
  logic [47:0]   r_res_hc;
  logic [47:0]   r_res_m;

  logic [7:0]    w_sym;
  logic          w_xfer;
  logic          w_legal;

  // Only the owner's lane is ever looked at; the other requester's valid
  // and data are don't-care for the whole job.
  assign w_sym   = r_owner ? bus.sym_data1 : bus.sym_data0;
  assign w_xfer  = (r_state == S_LOAD) && bus.sym_valid[r_owner];
  assign w_legal = (w_sym != 8'd0) && (w_sym <= 8'd6);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;  // requester 0 wins the first tie
      r_cnt        <= '0;
      r_timer      <= '0;
      r_fcnt       <= '0;
      r_core_rst   <= 1'b1;
      r_gray_valid <= 1'b0;
      r_gray_data  <= 8'd0;
      r_res_valid  <= 1'b0;
      r_res_id     <= 1'b0;
      r_res_err    <= 2'd0;
      r_res_hc     <= 48'd0;
      r_res_m      <= 48'd0;
    end else begin
      // Both strobes are single-cycle unless re-armed below.
      r_gray_valid <= 1'b0;
      r_res_valid  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_core_rst <= 1'b0;
          if (bus.req != 2'b00) begin
            r_owner <= (bus.req == 2'b11) ? ~r_last : bus.req[1];
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_xfer) begin
            if (w_legal) begin
              r_gray_valid <= 1'b1;
              r_gray_data  <= w_sym;
              r_cnt        <= r_cnt + CW'(1);
              if (r_cnt == CNT_LAST) begin
                r_timer <= '0;
                r_state <= S_WAIT;
              end
            end else begin
              // Bad symbol: never reaches the core; result goes out on entry
              // to ABORT so res_valid coincides with the ABORT cycle.
              r_res_valid <= 1'b1;
              r_res_id    <= r_owner;
              r_res_err   <= 2'd1;
              r_res_hc    <= 48'd0;
              r_res_m     <= 48'd0;
              r_state     <= S_ABORT;
            end
          end
        end

        S_WAIT: begin
          // code_valid is tested first so it wins over a same-cycle timeout.
          if (bus.core_code_valid) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_owner;
            r_res_err   <= 2'd0;
            r_res_hc    <= bus.core_hc;
            r_res_m     <= bus.core_m;
            r_state     <= S_DONE;
          end else if (r_timer == TMO_LAST) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_owner;
            r_res_err   <= 2'd2;
            r_res_hc    <= 48'd0;
            r_res_m     <= 48'd0;
            r_state     <= S_ABORT;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_DONE, S_ABORT: begin
          r_last     <= r_owner;
          r_core_rst <= 1'b1;
          r_fcnt     <= '0;
          r_state    <= S_FLUSH;
        end

        S_FLUSH: begin
          if (r_fcnt == FL_LAST) begin
            r_core_rst <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sym_ready       = (r_state == S_LOAD) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.core_rst        = r_core_rst;
  assign bus.core_gray_valid = r_gray_valid;
  assign bus.core_gray_data  = r_gray_data;
  assign bus.res_valid       = r_res_valid;
  assign bus.res_id          = r_res_id;
  assign bus.res_err         = r_res_err;
  assign bus.res_hc          = r_res_hc;
  assign bus.res_m           = r_res_m;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_huffman_job_sched.sv
// -----------------------------------------------------------------------------
// tb_huffman_job_sched
// Directed job table plus randomized jobs against a small reference model of
// the scheduler's arbitration and result rules. The core is modelled by the
// bench: it accepts gray pushes and raises code_valid a chosen number of
// cycles after the last symbol (or never).
// -----------------------------------------------------------------------------
module tb_huffman_job_sched;

  localparam int SYM_NUM = 100;
  localparam int TIMEOUT = 16;
  localparam int RST_CYC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_job_sched_if bus();

  huffman_job_sched #(
    .SYM_NUM(SYM_NUM),
    .TIMEOUT(TIMEOUT),
    .RST_CYC(RST_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];
  logic        prev_legal;
  logic [7:0]  last_gray;
  int          gray_cnt;
  logic        model_last;
  logic [7:0]  syms[SYM_NUM];

  typedef struct {
    logic [1:0] req;
    int         gap;
    int         bad_pos;   // -1: every symbol legal
    logic [7:0] bad_val;
    int         code_dly;  // 0: core never answers
    logic       exp_id;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] rand48();
    return {16'($urandom), $urandom};
  endfunction

  // Arbitration rule: single request wins, a tie goes to the one not served last.
  function automatic logic pick_owner(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  function automatic logic [7:0] sym_mix(input int i);
    if (i < 40) return 8'd1;
    if (i < 60) return 8'd2;
    if (i < 75) return 8'd3;
    if (i < 85) return 8'd4;
    if (i < 95) return 8'd5;
    return 8'd6;
  endfunction

  // ---------------- driver tasks ----------------
  // Owner lane gets (v, d); the other lane gets random junk that must be ignored.
  task automatic drive_sym(input logic own, input logic v, input logic [7:0] d);
    logic [7:0] junk;
    junk = 8'($urandom);
    if (own) begin
      bus.sym_valid = {v, 1'($urandom)};
      bus.sym_data1 = v ? d : junk;
      bus.sym_data0 = 8'($urandom);
    end else begin
      bus.sym_valid = {1'($urandom), v};
      bus.sym_data0 = v ? d : junk;
      bus.sym_data1 = 8'($urandom);
    end
  endtask

  task automatic drive_quiet();
    bus.sym_valid       = 2'b00;
    bus.sym_data0       = 8'd0;
    bus.sym_data1       = 8'd0;
    bus.core_code_valid = 1'b0;
  endtask

  // Advance to the next negedge and check the core push stream: a pulse
  // exactly one cycle after each legal accept, data in order, data held
  // otherwise, and sym_ready never two-hot.
  task automatic sample();
    @(negedge clk);
    check("gray_valid", bus.core_gray_valid, prev_legal);
    if (bus.core_gray_valid) begin
      gray_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL gray_extra: got data %0h want no pulse", bus.core_gray_data);
      end else begin
        last_gray = exp_q.pop_front();
        check("gray_data", bus.core_gray_data, last_gray);
      end
    end else begin
      check("gray_hold", bus.core_gray_data, last_gray);
    end
    check("ready_onehot", ($countones(bus.sym_ready) <= 1), 1'b1);
    prev_legal = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] req, input int gap, input int bad_pos,
                         input logic [7:0] bad_val, input int code_dly,
                         input logic exp_id, input logic [1:0] exp_err);
    logic [47:0] hc_v, m_v, exp_hc, exp_m;
    logic [1:0]  rdy;
    logic [7:0]  s;
    int          n_sym, g0, res_k, exp_k;
    hc_v   = rand48();
    m_v    = rand48();
    exp_hc = (exp_err == 2'd0) ? hc_v : 48'd0;
    exp_m  = (exp_err == 2'd0) ? m_v  : 48'd0;
    rdy    = exp_id ? 2'b10 : 2'b01;
    n_sym  = (bad_pos >= 0) ? bad_pos + 1 : SYM_NUM;
    g0     = gray_cnt;

    bus.req = req;
    sample();
    bus.req = 2'b00;  // dropping req mid-job must not matter
    check("grant_ready", bus.sym_ready, rdy);
    check("grant_busy", bus.busy, 1'b1);

    for (int i = 0; i < n_sym; i++) begin
      for (int g = 0; g < gap; g++) begin
        drive_sym(exp_id, 1'b0, 8'd0);
        sample();
        check("gap_ready", bus.sym_ready, rdy);
      end
      s = (i == bad_pos) ? bad_val : syms[i];
      drive_sym(exp_id, 1'b1, s);
      if (i != bad_pos) begin
        exp_q.push_back(s);
        prev_legal = 1'b1;
      end
      // A stray code_valid while loading must be ignored.
      bus.core_code_valid = (i == 10);
      bus.core_hc         = rand48();
      bus.core_m          = rand48();
      sample();
      check("load_ready", bus.sym_ready, (i == n_sym - 1) ? 2'b00 : rdy);
    end
    drive_quiet();

    // k counts negedges since the edge that accepted the last symbol.
    res_k = 0;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      if (k > 1) sample();
      if (bus.res_valid) begin
        res_k = k;
        break;
      end
      bus.core_code_valid = (code_dly > 0) && (k == code_dly);
      bus.core_hc         = bus.core_code_valid ? hc_v : rand48();
      bus.core_m          = bus.core_code_valid ? m_v  : rand48();
    end
    bus.core_code_valid = 1'b0;

    exp_k = (bad_pos >= 0) ? 1 : ((code_dly > 0) ? code_dly + 1 : TIMEOUT + 1);
    check("res_latency", res_k, exp_k);
    if (res_k != 0) begin
      check("res_id", bus.res_id, exp_id);
      check("res_err", bus.res_err, exp_err);
      check("res_hc", bus.res_hc, exp_hc);
      check("res_m", bus.res_m, exp_m);
      check("gray_count", gray_cnt - g0, (bad_pos >= 0) ? bad_pos : SYM_NUM);
      for (int c = 0; c < RST_CYC; c++) begin
        sample();
        check("flush_core_rst", bus.core_rst, 1'b1);
        check("flush_res_valid", bus.res_valid, 1'b0);
        check("flush_busy", bus.busy, 1'b1);
      end
      sample();
      check("idle_core_rst", bus.core_rst, 1'b0);
      check("idle_busy", bus.busy, 1'b0);
      check("hold_res_id", bus.res_id, exp_id);
      check("hold_res_hc", bus.res_hc, exp_hc);
      check("hold_res_m", bus.res_m, exp_m);
    end else begin
      for (int w = 0; w < 64 && bus.busy; w++) sample();
      if (bus.busy) begin
        $display("FAIL stuck_busy: got busy=1 want 0");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "scheduler stuck");
      end
    end
    exp_q.delete();
    model_last = exp_id;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [1:0] r;
    logic       own;
    int         mode, pos, dly;
    logic [7:0] bv;
    logic [1:0] er;

    reset      = 1'b1;
    bus.req    = 2'b00;
    bus.core_hc = 48'd0;
    bus.core_m  = 48'd0;
    drive_quiet();
    prev_legal = 1'b0;
    last_gray  = 8'd0;
    gray_cnt   = 0;
    model_last = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_core_rst", bus.core_rst, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_sym_ready", bus.sym_ready, 2'b00);
    check("rst_gray_valid", bus.core_gray_valid, 1'b0);
    check("rst_gray_data", bus.core_gray_data, 8'd0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_id", bus.res_id, 1'b0);
    check("rst_res_err", bus.res_err, 2'd0);
    check("rst_res_hc", bus.res_hc, 48'd0);
    check("rst_res_m", bus.res_m, 48'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_core_rst", bus.core_rst, 1'b0);

    // Directed jobs: {req, gap, bad_pos, bad_val, code_dly, exp_id, exp_err}
    vecs[0] = '{2'b11, 0, -1, 8'd0, 3, 1'b0, 2'd0};
    vecs[1] = '{2'b11, 0, -1, 8'd0, 5, 1'b1, 2'd0};
    vecs[2] = '{2'b11, 0, -1, 8'd0, TIMEOUT, 1'b0, 2'd0}; // code on last timeout cycle
    vecs[3] = '{2'b01, 0, -1, 8'd0, 4, 1'b0, 2'd0};
    vecs[4] = '{2'b10, 3, -1, 8'd0, 2, 1'b1, 2'd0};       // gaps between symbols
    vecs[5] = '{2'b01, 0, 36, 8'd0, 0, 1'b0, 2'd1};       // 37th symbol is 0
    vecs[6] = '{2'b10, 0, -1, 8'd0, 6, 1'b1, 2'd0};
    vecs[7] = '{2'b01, 0, -1, 8'd0, 0, 1'b0, 2'd2};       // core never answers
    vecs[8] = '{2'b10, 0, 0, 8'd7, 0, 1'b1, 2'd1};        // first symbol 7

    for (int i = 0; i < SYM_NUM; i++) syms[i] = sym_mix(i);
    for (int v = 0; v < 9; v++)
      run_job(vecs[v].req, vecs[v].gap, vecs[v].bad_pos, vecs[v].bad_val,
              vecs[v].code_dly, vecs[v].exp_id, vecs[v].exp_err);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < SYM_NUM; i++) syms[i] = 8'($urandom_range(1, 6));
      r    = 2'($urandom_range(1, 3));
      own  = pick_owner(r, model_last);
      mode = $urandom_range(0, 4);
      pos  = -1;
      bv   = 8'd0;
      dly  = $urandom_range(1, TIMEOUT);
      er   = 2'd0;
      if (mode == 0) begin
        pos = $urandom_range(0, SYM_NUM - 1);
        bv  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(7, 255));
        er  = 2'd1;
      end else if (mode == 1) begin
        dly = 0;
        er  = 2'd2;
      end
      run_job(r, $urandom_range(0, 1), pos, bv, dly, own, er);
    end

    // Reset in the middle of a load kills the job without a result.
    for (int i = 0; i < SYM_NUM; i++) syms[i] = sym_mix(i);
    bus.req = 2'b01;
    sample();
    bus.req = 2'b00;
    for (int i = 0; i < 50; i++) begin
      drive_sym(1'b0, 1'b1, syms[i]);
      exp_q.push_back(syms[i]);
      prev_legal = 1'b1;
      sample();
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_core_rst", bus.core_rst, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ready", bus.sym_ready, 2'b00);
    check("mid_rst_gray_valid", bus.core_gray_valid, 1'b0);
    check("mid_rst_gray_data", bus.core_gray_data, 8'd0);
    check("mid_rst_res_hc", bus.res_hc, 48'd0);
    check("mid_rst_res_id", bus.res_id, 1'b0);
    drive_quiet();
    exp_q.delete();
    prev_legal = 1'b0;
    last_gray  = 8'd0;
    model_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_res_valid", bus.res_valid, 1'b0);
      check("mid_rst_core_rst_hold", bus.core_rst, 1'b1);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_core_rst", bus.core_rst, 1'b0);
    run_job(2'b01, 0, -1, 8'd0, 7, 1'b0, 2'd0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
